// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
// One request strobe with a word address, one response strobe with the word.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;

    // Fetch stage side: issues requests, receives instruction words
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    // Memory side: accepts requests, returns instruction words
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC, keeps a single request outstanding to instruction memory,
// splits each returned word into its fields and presents it with its PC.
// A one-word buffer absorbs a response that lands while IF/ID is stalled;
// a drop flag discards a response whose request was overtaken by a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] PC_STEP   = 32'd1,
    parameter logic [4:0]  BUBBLE_OP = 5'b11111
) (
    input  logic         clk,
    input  logic         Reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    fetch_unit_if.master imem,
    output logic         out_valid,
    output logic [4:0]   Opcode,
    output logic [4:0]   Rd,
    output logic [4:0]   Rs,
    output logic [4:0]   Rt,
    output logic [16:0]  Imm,
    output logic [31:0]  Jaddr,
    output logic [31:0]  Pc
);

    // FETCH issues the request, WAIT awaits the response, HOLD keeps a
    // captured word until IF/ID can accept it.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [16:0] imm;
        logic [31:0] jaddr;
    } fields_t;

    // Field split of one instruction word; Rt and Imm overlap on purpose.
    function automatic fields_t decode(input logic [31:0] instr);
        fields_t f;
        f.opcode = instr[31:27];
        f.rd     = instr[26:22];
        f.rs     = instr[21:17];
        f.rt     = instr[16:12];
        f.imm    = instr[16:0];
        f.jaddr  = {5'd0, instr[26:0]};
        return f;
    endfunction

    state_t      state_r;
    state_t      state_s;
    logic [31:0] pc_r;
    logic [31:0] pc_s;
    logic        drop_r;
    logic        drop_s;
    logic [31:0] buf_word_r;
    logic [31:0] buf_word_s;
    logic [31:0] buf_pc_r;
    logic [31:0] buf_pc_s;

    logic        load_s;
    logic [31:0] load_word_s;
    logic [31:0] load_pc_s;
    logic        bubble_s;
    fields_t     dec_s;

    logic        out_valid_r;
    logic [4:0]  opcode_r;
    logic [4:0]  rd_r;
    logic [4:0]  rs_r;
    logic [4:0]  rt_r;
    logic [16:0] imm_r;
    logic [31:0] jaddr_r;
    logic [31:0] pc_out_r;

    // Request is issued from FETCH only, so at most one is ever outstanding.
    assign imem.imem_req  = (state_r == FETCH) && !Reset;
    assign imem.imem_addr = pc_r;

    // Next-state, next-PC, buffer and output-load decisions; redirect outranks stall
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        drop_s      = drop_r;
        buf_word_s  = buf_word_r;
        buf_pc_s    = buf_pc_r;
        load_s      = 1'b0;
        load_word_s = buf_word_r;
        load_pc_s   = buf_pc_r;
        bubble_s    = 1'b0;
        if (redirect) begin
            pc_s     = redirect_pc;
            bubble_s = 1'b1;
            case (state_r)
                FETCH: begin
                    // The request going out this cycle is for the old path.
                    state_s = WAIT;
                    drop_s  = 1'b1;
                end
                WAIT: begin
                    if (imem.imem_valid) begin
                        state_s = FETCH;
                        drop_s  = 1'b0;
                    end else begin
                        state_s = WAIT;
                        drop_s  = 1'b1;
                    end
                end
                HOLD: begin
                    state_s    = FETCH;
                    drop_s     = 1'b0;
                    buf_word_s = 32'd0;
                    buf_pc_s   = 32'd0;
                end
                default: begin
                    state_s = FETCH;
                    drop_s  = 1'b0;
                end
            endcase
        end else begin
            // Without a load, an unstalled IF/ID sees a bubble; a stalled one holds.
            bubble_s = ~stall;
            case (state_r)
                FETCH: begin
                    state_s = WAIT;
                end
                WAIT: begin
                    if (!imem.imem_valid) begin
                        state_s = WAIT;
                    end else if (drop_r) begin
                        drop_s  = 1'b0;
                        state_s = FETCH;
                    end else if (!stall) begin
                        load_s      = 1'b1;
                        load_word_s = imem.imem_rdata;
                        load_pc_s   = pc_r;
                        pc_s        = pc_r + PC_STEP;
                        state_s     = FETCH;
                    end else begin
                        buf_word_s = imem.imem_rdata;
                        buf_pc_s   = pc_r;
                        state_s    = HOLD;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        state_s = HOLD;
                    end else begin
                        load_s  = 1'b1;
                        pc_s    = pc_r + PC_STEP;
                        state_s = FETCH;
                    end
                end
                default: begin
                    state_s = FETCH;
                    drop_s  = 1'b0;
                end
            endcase
        end
    end

    // Field split of whichever word is being loaded into IF/ID
    always_comb begin
        dec_s = decode(load_word_s);
    end

    // FSM state, PC, drop flag and stall buffer registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            drop_r     <= 1'b0;
            buf_word_r <= 32'd0;
            buf_pc_r   <= 32'd0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            drop_r     <= drop_s;
            buf_word_r <= buf_word_s;
            buf_pc_r   <= buf_pc_s;
        end
    end

    // IF/ID output registers: load a word, insert a bubble, or hold
    always_ff @(posedge clk) begin
        if (Reset) begin
            out_valid_r <= 1'b0;
            opcode_r    <= BUBBLE_OP;
            rd_r        <= 5'd0;
            rs_r        <= 5'd0;
            rt_r        <= 5'd0;
            imm_r       <= 17'd0;
            jaddr_r     <= 32'd0;
            pc_out_r    <= 32'd0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            opcode_r    <= dec_s.opcode;
            rd_r        <= dec_s.rd;
            rs_r        <= dec_s.rs;
            rt_r        <= dec_s.rt;
            imm_r       <= dec_s.imm;
            jaddr_r     <= dec_s.jaddr;
            pc_out_r    <= load_pc_s;
        end else if (bubble_s) begin
            // Only validity and opcode matter for a bubble; fields keep their value.
            out_valid_r <= 1'b0;
            opcode_r    <= BUBBLE_OP;
        end else begin
            out_valid_r <= out_valid_r;
            opcode_r    <= opcode_r;
        end
    end

    assign out_valid = out_valid_r;
    assign Opcode    = opcode_r;
    assign Rd        = rd_r;
    assign Rs        = rs_r;
    assign Rt        = rt_r;
    assign Imm       = imm_r;
    assign Jaddr     = jaddr_r;
    assign Pc        = pc_out_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a decode vector table, directed
// stall/redirect/wrap/reset sequences, then randomized traffic checked
// against an in-order stream model with a pending-word queue.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [4:0]  Opcode;
    logic [4:0]  Rd;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [16:0] Imm;
    logic [31:0] Jaddr;
    logic [31:0] Pc;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk         (clk),
        .Reset       (Reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .out_valid   (out_valid),
        .Opcode      (Opcode),
        .Rd          (Rd),
        .Rs          (Rs),
        .Rt          (Rt),
        .Imm         (Imm),
        .Jaddr       (Jaddr),
        .Pc          (Pc)
    );

    int total = 0;
    int bad   = 0;

    // stimulus knobs
    logic        rst_v;
    logic        stall_v;
    logic        redir_v;
    logic [31:0] rpc_v;
    int          lat_fix;

    // memory responder
    bit [31:0]   ovr [bit [31:0]];
    logic        outstanding;
    int          remaining;
    logic [31:0] resp_addr;
    int          resp_epoch;
    logic        last_req;
    logic [31:0] last_addr;

    // reference model
    typedef struct {
        logic [31:0] a;
        logic [31:0] w;
    } ent_t;
    ent_t        pend[$];
    int          epoch;
    logic [31:0] exp_pc;
    int          reqs_since;
    logic        e_valid;
    logic [4:0]  e_op;
    logic [4:0]  e_rd;
    logic [4:0]  e_rs;
    logic [4:0]  e_rt;
    logic [16:0] e_imm;
    logic [31:0] e_jaddr;
    logic [31:0] e_pc;
    logic        known;

    typedef struct {
        logic [31:0] word;
        logic [4:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [16:0] imm;
        logic [31:0] jaddr;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (ovr.exists(a)) return ovr[a];
        else return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // One clock cycle: drive inputs, serve memory, step model, compare outputs.
    task automatic cycle();
        logic        v;
        logic [31:0] d;
        logic [31:0] raddr;
        int          rep;
        logic        busy;
        ent_t        ent;
        v = 1'b0;
        d = 32'd0;
        if (rst_v) begin
            outstanding = 1'b0;
        end else if (outstanding) begin
            remaining--;
            if (remaining <= 0) begin
                v = 1'b1;
                d = word_at(resp_addr);
            end
        end
        raddr = resp_addr;
        rep   = resp_epoch;
        Reset       = rst_v;
        stall       = stall_v;
        redirect    = redir_v;
        redirect_pc = rpc_v;
        bus.imem_valid = v;
        bus.imem_rdata = d;
        #1;
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        busy = outstanding;
        if (v) outstanding = 1'b0;
        if (rst_v) chk("req_in_reset", 32'(last_req), 32'd0);
        if (last_req) begin
            chk("one_outstanding", 32'(busy), 32'd0);
            chk("req_addr", last_addr, exp_pc);
            chk("dup_req", 32'(reqs_since), 32'd0);
            reqs_since++;
            outstanding = 1'b1;
            remaining   = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4));
            resp_addr   = last_addr;
            resp_epoch  = epoch;
        end
        @(posedge clk);
        if (rst_v) begin
            pend.delete();
            epoch++;
            exp_pc = 32'd0; reqs_since = 0;
            e_valid = 1'b0; e_op = 5'h1F; e_rd = 5'd0; e_rs = 5'd0; e_rt = 5'd0;
            e_imm = 17'd0; e_jaddr = 32'd0; e_pc = 32'd0; known = 1'b1;
        end else begin
            if (v && rep == epoch && !redir_v) pend.push_back('{a: raddr, w: d});
            if (redir_v) begin
                pend.delete();
                epoch++;
                exp_pc = rpc_v; reqs_since = 0;
                e_valid = 1'b0; e_op = 5'h1F; known = 1'b0;
            end else if (!stall_v && pend.size() > 0) begin
                ent = pend.pop_front();
                e_valid = 1'b1;
                e_op    = ent.w[31:27];
                e_rd    = ent.w[26:22];
                e_rs    = ent.w[21:17];
                e_rt    = ent.w[16:12];
                e_imm   = ent.w[16:0];
                e_jaddr = ent.w & 32'h07FF_FFFF;
                e_pc    = ent.a;
                known   = 1'b1;
                exp_pc  = ent.a + 32'd1;
                reqs_since = 0;
            end else if (!stall_v) begin
                e_valid = 1'b0; e_op = 5'h1F; known = 1'b0;
            end else begin
                known = known;
            end
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(e_valid));
        chk("opcode", 32'(Opcode), 32'(e_op));
        if (known) begin
            chk("rd", 32'(Rd), 32'(e_rd));
            chk("rs", 32'(Rs), 32'(e_rs));
            chk("rt", 32'(Rt), 32'(e_rt));
            chk("imm", 32'(Imm), 32'(e_imm));
            chk("jaddr", Jaddr, e_jaddr);
            chk("pc", Pc, e_pc);
        end
    endtask

    // Run cycles until the word at p is presented; report cycles and first request address.
    task automatic wait_present(input logic [31:0] p, output int n, output logic [31:0] seen);
        logic got;
        n    = 0;
        seen = 32'hDEAD_BEEF;
        got  = 1'b0;
        while (!got && n < 40) begin
            cycle();
            n++;
            if (last_req && seen == 32'hDEAD_BEEF) seen = last_addr;
            got = (out_valid === 1'b1) && (Pc === p);
        end
        chk("present_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        int          n;
        logic [31:0] seen;
        logic        s_valid;
        logic [4:0]  s_op;
        logic [31:0] s_pc;
        logic [16:0] s_imm;
        int          r;

        tbl[0] = '{32'h19440ABC, 5'd3,  5'd5,  5'd2,  5'd0,  17'h00ABC, 32'h01440ABC};
        tbl[1] = '{32'hFFFFFFFF, 5'd31, 5'd31, 5'd31, 5'd31, 17'h1FFFF, 32'h07FFFFFF};
        tbl[2] = '{32'h00000000, 5'd0,  5'd0,  5'd0,  5'd0,  17'h00000, 32'h00000000};
        tbl[3] = '{32'h87654321, 5'd16, 5'd29, 5'd18, 5'd20, 17'h14321, 32'h07654321};
        tbl[4] = '{32'h08421000, 5'd1,  5'd1,  5'd1,  5'd1,  17'h01000, 32'h00421000};
        tbl[5] = '{32'hF8000000, 5'd31, 5'd0,  5'd0,  5'd0,  17'h00000, 32'h00000000};
        for (int i = 0; i < 6; i++) ovr[32'(i)] = tbl[i].word;

        outstanding = 1'b0; remaining = 0; resp_addr = 32'd0; resp_epoch = 0;
        epoch = 0; exp_pc = 32'd0; reqs_since = 0; known = 1'b0;
        e_valid = 1'b0; e_op = 5'h1F; e_rd = 5'd0; e_rs = 5'd0; e_rt = 5'd0;
        e_imm = 17'd0; e_jaddr = 32'd0; e_pc = 32'd0;
        rst_v = 1'b1; stall_v = 1'b0; redir_v = 1'b0; rpc_v = 32'd0; lat_fix = 1;

        // reset for two cycles
        cycle();
        cycle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_opcode", 32'(Opcode), 32'h1F);
        chk("rst_pc", Pc, 32'd0);
        rst_v = 1'b0;
        cycle();
        chk("first_req", 32'(last_req), 32'd1);
        chk("first_addr", last_addr, 32'd0);

        // decode table at latency 1, no stall: one instruction per two cycles
        for (int i = 0; i < 6; i++) begin
            wait_present(32'(i), n, seen);
            chk("tbl_valid", 32'(out_valid), 32'd1);
            chk("tbl_op", 32'(Opcode), 32'(tbl[i].op));
            chk("tbl_rd", 32'(Rd), 32'(tbl[i].rd));
            chk("tbl_rs", 32'(Rs), 32'(tbl[i].rs));
            chk("tbl_rt", 32'(Rt), 32'(tbl[i].rt));
            chk("tbl_imm", 32'(Imm), 32'(tbl[i].imm));
            chk("tbl_jaddr", Jaddr, tbl[i].jaddr);
            chk("tbl_pc", Pc, 32'(i));
            if (i > 0) begin
                chk("tbl_rate", 32'(n), 32'd2);
                chk("tbl_fetch_addr", seen, 32'(i));
            end
        end

        // stall across the response: outputs frozen, no second request
        s_valid = out_valid; s_op = Opcode; s_pc = Pc; s_imm = Imm;
        stall_v = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("stall_valid", 32'(out_valid), 32'(s_valid));
            chk("stall_op", 32'(Opcode), 32'(s_op));
            chk("stall_pc", Pc, s_pc);
            chk("stall_imm", 32'(Imm), 32'(s_imm));
            chk("stall_req", 32'(last_req), (k == 0) ? 32'd1 : 32'd0);
        end
        stall_v = 1'b0;
        cycle();
        chk("unstall_valid", 32'(out_valid), 32'd1);
        chk("unstall_pc", Pc, 32'd6);
        chk("unstall_noreq", 32'(last_req), 32'd0);
        lat_fix = 3;
        cycle();
        chk("unstall_next", last_addr, 32'd7);

        // redirect in WAIT; stale response lands two cycles later
        redir_v = 1'b1; rpc_v = 32'h40;
        cycle();
        chk("redir_bubble", 32'(out_valid), 32'd0);
        redir_v = 1'b0;
        cycle();
        chk("redir_wait1", 32'(out_valid), 32'd0);
        cycle();
        chk("redir_drop", 32'(out_valid), 32'd0);
        cycle();
        chk("redir_req", 32'(last_req), 32'd1);
        chk("redir_addr", last_addr, 32'h40);
        lat_fix = 1;
        wait_present(32'h40, n, seen);

        // stall and redirect together: bubble wins, fetch resumes at target
        stall_v = 1'b1; redir_v = 1'b1; rpc_v = 32'h80;
        cycle();
        chk("sr_valid", 32'(out_valid), 32'd0);
        chk("sr_opcode", 32'(Opcode), 32'h1F);
        redir_v = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("sr_hold", 32'(out_valid), 32'd0);
        end
        stall_v = 1'b0;
        wait_present(32'h80, n, seen);
        chk("sr_resume_lat", 32'(n), 32'd1);

        // PC wrap
        redir_v = 1'b1; rpc_v = 32'hFFFF_FFFF;
        cycle();
        redir_v = 1'b0;
        wait_present(32'hFFFF_FFFF, n, seen);
        chk("wrap_fetch_addr", seen, 32'hFFFF_FFFF);
        chk("wrap_pc", Pc, 32'hFFFF_FFFF);
        cycle();
        chk("wrap_next_req", 32'(last_req), 32'd1);
        chk("wrap_next_addr", last_addr, 32'd0);

        // reset while a fetch is in flight
        lat_fix = 3;
        cycle();
        rst_v = 1'b1;
        cycle();
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_opcode", 32'(Opcode), 32'h1F);
        chk("midrst_jaddr", Jaddr, 32'd0);
        rst_v = 1'b0;
        cycle();
        chk("midrst_req", 32'(last_req), 32'd1);
        chk("midrst_addr", last_addr, 32'd0);

        // randomized traffic against the model
        lat_fix = 0;
        for (int c = 0; c < 4000; c++) begin
            r = int'($urandom_range(0, 199));
            rst_v   = (r == 0);
            stall_v = ($urandom_range(0, 99) < 35);
            redir_v = ($urandom_range(0, 99) < 6);
            case ($urandom_range(0, 3))
                0:       rpc_v = 32'hFFFF_FFFE;
                1:       rpc_v = $urandom;
                default: rpc_v = 32'($urandom_range(0, 255));
            endcase
            cycle();
        end

        // forward progress once traffic calms down
        rst_v = 1'b0; stall_v = 1'b0; redir_v = 1'b0; lat_fix = 2;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            cycle();
            n++;
        end
        chk("drain_progress", 32'(out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
